// File: rtl/pwm_timer.sv
// pwm_timer: prescaled auto-reload up-counter with NCH compare/PWM channels.
// Prescaler, reload and compare values are held in shadow registers that only
// reload while idle or at a period wrap, so mid-period writes never tear a period.
module pwm_timer #(
    parameter int unsigned PSC_W = 5,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned NCH   = 2
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_en,
    input  logic                 i_mode,
    input  logic [PSC_W-1:0]     i_psc,
    input  logic [CNT_W-1:0]     i_arr,
    input  logic [NCH*CNT_W-1:0] i_ccr,
    output logic [CNT_W-1:0]     o_cnt,
    output logic                 o_tick,
    output logic                 o_done,
    output logic [NCH-1:0]       o_pwm
);

    logic [PSC_W-1:0]     r_pc;
    logic [CNT_W-1:0]     r_cnt;
    logic [PSC_W-1:0]     r_psc_s;
    logic [CNT_W-1:0]     r_arr_s;
    logic [NCH*CNT_W-1:0] r_ccr_s;
    logic                 r_tick;
    logic                 r_done;

    logic [PSC_W-1:0]     w_pc_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_tick_nxt;
    logic                 w_done_nxt;
    logic                 w_load;

    // Next-state: idle clears and tracks inputs, done parks at zero, run counts.
    always_comb begin
        w_pc_nxt   = r_pc;
        w_cnt_nxt  = r_cnt;
        w_tick_nxt = 1'b0;
        w_done_nxt = r_done;
        w_load     = 1'b0;
        if (!i_en) begin
            w_pc_nxt   = '0;
            w_cnt_nxt  = '0;
            w_done_nxt = 1'b0;
            w_load     = 1'b1;
        end else if (r_done) begin
            w_pc_nxt  = '0;
            w_cnt_nxt = '0;
        end else if (r_pc != r_psc_s) begin
            w_pc_nxt = r_pc + 1'b1;
        end else begin
            w_pc_nxt = '0;
            if (r_cnt != r_arr_s) begin
                w_cnt_nxt = r_cnt + 1'b1;
            end else begin
                // Period wrap: pulse tick, pick up new settings, maybe stop.
                w_cnt_nxt  = '0;
                w_tick_nxt = 1'b1;
                w_load     = 1'b1;
                if (i_mode) begin
                    w_done_nxt = 1'b1;
                end
            end
        end
    end

    // State and shadow registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_pc    <= '0;
            r_cnt   <= '0;
            r_psc_s <= '0;
            r_arr_s <= '0;
            r_ccr_s <= '0;
            r_tick  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_pc   <= w_pc_nxt;
            r_cnt  <= w_cnt_nxt;
            r_tick <= w_tick_nxt;
            r_done <= w_done_nxt;
            if (w_load) begin
                r_psc_s <= i_psc;
                r_arr_s <= i_arr;
                r_ccr_s <= i_ccr;
            end
        end
    end

    // PWM levels: high while counter is below the channel's shadowed compare.
    always_comb begin
        o_pwm = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            o_pwm[i] = i_en & ~r_done & (r_cnt < r_ccr_s[i*CNT_W +: CNT_W]);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_tick = r_tick;
    assign o_done = r_done;

endmodule

// File: doc/pwm_timer.md
# pwm_timer

Parametrised successor to the single prescaled tick counter: a prescaler feeding an auto-reload up-counter with NCH compare channels. It produces a one-cycle update tick per period, per-channel PWM levels, and a one-shot mode. Prescaler, reload and compare values are shadowed, so software-side changes take effect only at period boundaries. It sits beside the existing counter as the general timer for lab peripherals.

## Interface
- PSC_W, 5, prescaler width
- CNT_W, 8, main counter width
- NCH, 2, number of compare/PWM channels (≥1)

- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- en  in  1  run enable, level
- mode  in  1  0 = periodic, 1 = one-shot
- psc  in  PSC_W  prescale value; count rate = clk/(psc+1)
- arr  in  CNT_W  auto-reload value; counter runs 0..arr
- ccr  in  NCH*CNT_W  compare values; channel i at bits [i*CNT_W +: CNT_W]
- cnt  out  CNT_W  current counter value
- tick  out  1  one-cycle update pulse at period wrap
- done  out  1  one-shot completed, sticky
- pwm  out  NCH  per-channel PWM level

## Operation
- Internal registers:
  - pc (PSC_W), prescaler count.
  - cnt.
  - Shadows psc_s, arr_s, ccr_s.
  - tick, done.
- Reset (reset = 0 at an edge): pc, cnt, psc_s, arr_s, ccr_s, tick and done all clear to 0. Outputs are therefore cnt = 0, tick = 0, done = 0, pwm = 0.
- Idle (en = 0):
  - pc and cnt are cleared.
  - tick and done are cleared.
  - Shadows load psc/arr/ccr every cycle.
- Running (en = 1, done = 0), evaluated each edge:
  - If pc ≠ psc_s: pc ← pc+1.
  - If pc = psc_s (base tick): pc ← 0, and:
    - if cnt ≠ arr_s: cnt ← cnt+1 and tick ← 0;
    - if cnt = arr_s (wrap): cnt ← 0, tick ← 1, shadows reload from psc/arr/ccr, and if mode = 1 then done ← 1.
  - In all other edges, tick ← 0.
- Done (en = 1, done = 1):
  - pc and cnt are held at 0, tick = 0, shadows frozen.
  - done clears only when en = 0.
- pwm[i] is combinational from registers: en & ~done & (cnt < ccr_s[i]).
  - ccr_s[i] = 0 gives pwm always 0.
  - ccr_s[i] > arr_s gives pwm always 1 while running.
- mode is sampled live at the wrap edge. Changing mode mid-period is legal.
- psc/arr/ccr changes while running have no effect until the next wrap edge.

## Timing
- Period = (psc_s+1)·(arr_s+1) clocks. The tick pulse is exactly 1 cycle wide and is high in the cycle where cnt reads 0 after a wrap.
- First period after en rises:
  - The first edge with en = 1 increments pc, or cnt if psc_s = 0.
  - The first tick appears (psc+1)·(arr+1) edges after the first en-high edge.
- arr_s = 0: cnt stays 0, and tick pulses every psc_s+1 clocks.
- psc_s = 0 and arr_s = 0: tick stays high continuously while running (periodic mode).
- en falling mid-period: at the next edge cnt = 0, pc = 0, tick = 0. pwm drops to 0 combinationally.
- Reset during run or done: outputs reach reset values after that edge. Reset takes priority over en.
- Counters never exceed psc_s/arr_s. Comparison uses the full CNT_W width, unsigned.

## Test plan
- Reset: hold reset = 0 for 2 cycles with en = 1 → cnt = 0, tick = 0, done = 0, pwm = 0. Release and set en = 0 for 1 cycle.
- Periodic: psc = 10, arr = 4, en = 1 → cnt steps every 11 clocks through 0..4. tick is 1-cycle high every 55 clocks, first at edge 55.
- PWM: psc = 0, arr = 9, ccr = {ch1 = 0, ch0 = 3} → pwm[0] is high for 3 of every 10 clocks, and pwm[1] stays 0. Then ccr ch0 = 12 → pwm[0] goes constant 1 starting from the next period.
- Shadowing: during a run with arr = 4, change arr to 7 mid-period → the current period still wraps at 4, and the following period wraps at 7.
- One-shot: mode = 1, psc = 1, arr = 3 → a single tick at edge 8, then done = 1 with cnt held at 0 and no further ticks. Drop en for 1 cycle and reassert → done clears and a new period runs.
- Abort: en falls while cnt = 2 → next cycle cnt = 0, pwm = 0, no tick. Reassert en → a full period is needed before the first tick.
